pit_spi_loader: RTL and testbench

PIT_SPI_LOADER -- requirements
Module: pit_spi_loader

---
 rtl/pit_spi_loader.sv | 178 +++++++++++++++++
 tb/tb_pit_spi_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pit_spi_loader.sv
// pit_spi_loader: SPI mode-0 slave that loads timer registers.
// A frame is a command byte followed by a data byte. Command bit7 = W
// (1 = write), bits 1:0 = register address. Write frames produce a
// single-cycle wr_en strobe. Read frames shift out a status snapshot on
// MISO during the command byte.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on spi_sck/spi_cs_n/spi_mosi (2..4)
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   spi_sck      SPI clock (mode 0, async to clk)
//   spi_cs_n     active-low frame select (async to clk)
//   spi_mosi     serial data in, MSB first
//   spi_miso     serial data out, MSB first
//   status_in    timer status byte returned on the command byte
//   wr_en        one-cycle register write strobe
//   wr_addr      register address (held until the next write)
//   wr_data      register data (held until the next write)
//   frame_err    one-cycle pulse when a frame is aborted
module pit_spi_loader #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] status_in,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    localparam int unsigned SYNC_W = SYNC_STAGES;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    logic [SYNC_W-1:0] sck_sync;
    logic [SYNC_W-1:0] cs_sync;
    logic [SYNC_W-1:0] mosi_sync;
    logic [SYNC_W-1:0] cs_vld;
    logic              armed;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        shift_sr;
    logic [7:0]        miso_sr;
    logic              cmd_w;
    logic [1:0]        cmd_addr;

    logic              sck_rise_c;
    logic              sck_fall_c;
    logic              cs_fall_c;
    logic              cs_rise_c;
    logic              mosi_bit_c;
    logic [7:0]        shift_next_c;

    // Input synchronizers; cs_n presets high so reset never looks like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            cs_vld    <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_W-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_W-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_W-2:0], spi_mosi};
            cs_vld    <= {cs_vld[SYNC_W-2:0], 1'b1};
        end
    end

    // Armed only once a genuine high level of cs_n has propagated through the
    // synchronizer after reset; a frame needs a fresh high-to-low transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (cs_vld[SYNC_W-1] && cs_sync[SYNC_W-1]) begin
            armed <= 1'b1;
        end
    end

    // Edge detects from the last two synchronizer stages.
    assign sck_rise_c   =  sck_sync[SYNC_W-2] & ~sck_sync[SYNC_W-1];
    assign sck_fall_c   = ~sck_sync[SYNC_W-2] &  sck_sync[SYNC_W-1];
    assign cs_fall_c    = ~cs_sync[SYNC_W-2]  &  cs_sync[SYNC_W-1] & armed;
    assign cs_rise_c    =  cs_sync[SYNC_W-2]  & ~cs_sync[SYNC_W-1];
    assign mosi_bit_c   =  mosi_sync[SYNC_W-1];
    assign shift_next_c = {shift_sr[6:0], mosi_bit_c};

    // Frame FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_sr  <= '0;
            miso_sr   <= '0;
            cmd_w     <= 1'b0;
            cmd_addr  <= '0;
            spi_miso  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall_c) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        shift_sr <= '0;
                        miso_sr  <= status_in;
                        spi_miso <= status_in[7];
                    end
                end
                CMD: begin
                    if (cs_rise_c) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        spi_miso  <= 1'b0;
                    end else if (sck_rise_c) begin
                        shift_sr <= shift_next_c;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(7)) begin
                            cmd_w    <= shift_next_c[7];
                            cmd_addr <= shift_next_c[1:0];
                            state    <= DATA;
                            spi_miso <= 1'b0;
                        end
                    end else if (sck_fall_c) begin
                        miso_sr  <= {miso_sr[6:0], 1'b0};
                        spi_miso <= miso_sr[6];
                    end
                end
                DATA: begin
                    // The last bit wins over a simultaneous cs_n rise.
                    if (sck_rise_c && (bit_cnt == CNT_W'(15))) begin
                        state    <= DONE;
                        shift_sr <= shift_next_c;
                        if (cmd_w) begin
                            wr_en   <= 1'b1;
                            wr_addr <= cmd_addr;
                            wr_data <= shift_next_c;
                        end
                    end else if (cs_rise_c) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (sck_rise_c) begin
                        shift_sr <= shift_next_c;
                        bit_cnt  <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Further sck activity is ignored; counter stays at 15.
                    spi_miso <= 1'b0;
                    if (cs_rise_c) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_spi_loader.sv
// Testbench for pit_spi_loader: directed SPI frames with a scoreboard of
// expected writes, frame errors and MISO bits, checked by monitor processes.
module tb_pit_spi_loader;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF_CLKS   = 6;

    logic       clk;
    logic       rst_n;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] status_in;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    wr_exp_t wr_q[$];
    logic    miso_q[$];
    int      err_expected;
    int      tests;
    int      fails;
    int      frame_bit;
    time     t16;

    pit_spi_loader #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .status_in(status_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cs_low();
        spi_cs_n  = 1'b0;
        frame_bit = 0;
        wclk(HALF_CLKS);
    endtask

    task automatic cs_high(input int n);
        spi_cs_n = 1'b1;
        wclk(n);
    endtask

    task automatic send_bits(input logic [23:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = data[i];
            wclk(HALF_CLKS);
            spi_sck = 1'b1;
            frame_bit++;
            if (frame_bit == 16) t16 = $time;
            wclk(HALF_CLKS);
            spi_sck = 1'b0;
        end
        wclk(HALF_CLKS);
    endtask

    task automatic expect_wr(input logic [1:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    // Write strobe monitor.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (wr_q.size() == 0) begin
                check("unexpected_wr_en", 32'(wr_en), 32'd0);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("wr_latency_within_4clk", 32'(($time - t16) <= 40), 32'd1);
            end
        end
    end

    // Frame error monitor.
    always @(negedge clk) begin
        if (rst_n && frame_err) begin
            if (err_expected == 0) begin
                check("unexpected_frame_err", 32'(frame_err), 32'd0);
            end else begin
                err_expected--;
                check("frame_err_pulse", 32'(frame_err), 32'd1);
            end
        end
    end

    // MISO monitor: master samples on the pin-level sck rise.
    always @(posedge spi_sck) begin
        if (miso_q.size() != 0) begin
            logic b;
            b = miso_q.pop_front();
            check("spi_miso_bit", 32'(spi_miso), 32'(b));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        err_expected = 0;
        frame_bit    = 0;
        t16          = 0;
        rst_n        = 1'b0;
        spi_sck      = 1'b0;
        spi_cs_n     = 1'b1;
        spi_mosi     = 1'b0;
        status_in    = 8'h00;
        wclk(2);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_spi_miso", 32'(spi_miso), 32'd0);
        rst_n = 1'b1;
        wclk(6);

        // Write 0x81,0x34 -> (01, 0x34).
        expect_wr(2'b01, 8'h34);
        cs_low();
        send_bits(24'h8134, 16);
        cs_high(6);

        // Read 0x00,0x00 with status 0xC8; status changes after cs fall.
        status_in = 8'hC8;
        miso_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cs_low();
        status_in = 8'hFF;
        send_bits(24'h0000, 16);
        cs_high(6);
        check("miso_bits_consumed", 32'(miso_q.size()), 32'd0);
        check("miso_idle_zero", 32'(spi_miso), 32'd0);

        // Abort after 9 rises: frame_err, write registers unchanged.
        err_expected++;
        cs_low();
        send_bits(24'h0105, 9);
        cs_high(6);
        check("abort_err_seen", 32'(err_expected), 32'd0);
        check("abort_keeps_wr_data", 32'(wr_data), 32'h34);
        check("abort_keeps_wr_addr", 32'(wr_addr), 32'h1);

        // 24 pulses: only the first 16 bits are used.
        expect_wr(2'b10, 8'h5A);
        cs_low();
        send_bits(24'h825AFF, 24);
        cs_high(6);
        check("over_clocked_single_wr", 32'(wr_q.size()), 32'd0);

        // Reset after 12 bits; cs_n stays low so no frame may start.
        cs_low();
        send_bits(24'h0C15, 12);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_spi_miso", 32'(spi_miso), 32'd0);
        wclk(3);
        rst_n = 1'b1;
        wclk(4);
        frame_bit = 0;
        send_bits(24'h8177, 16);
        cs_high(6);
        check("post_rst_wr_data", 32'(wr_data), 32'd0);

        // Back-to-back frames with cs_n high for 4 clk.
        expect_wr(2'b00, 8'hC0);
        expect_wr(2'b01, 8'h12);
        cs_low();
        send_bits(24'h80C0, 16);
        cs_high(4);
        cs_low();
        send_bits(24'h8112, 16);
        cs_high(20);

        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("err_queue_drained", 32'(err_expected), 32'd0);
        check("final_frame_err_low", 32'(frame_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
